// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the MEM-stage data RAM controller: access opcodes,
// FSM state encodings, RAM enable levels and the opcode-to-size decode.
package mem_ctrl_pkg;

  localparam logic [3:0] OP_LB  = 4'h0;
  localparam logic [3:0] OP_LH  = 4'h1;
  localparam logic [3:0] OP_LW  = 4'h2;
  localparam logic [3:0] OP_LBU = 4'h4;
  localparam logic [3:0] OP_LHU = 4'h5;
  localparam logic [3:0] OP_SB  = 4'h8;
  localparam logic [3:0] OP_SH  = 4'h9;
  localparam logic [3:0] OP_SW  = 4'hA;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic CE_ON  = 1'b1;
  localparam logic CE_OFF = 1'b0;
  localparam logic WE_WR  = 1'b1;
  localparam logic WE_RD  = 1'b0;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_BAD = 2'd3
  } size_e;

  // Undefined opcodes decode to SZ_BAD so they are reported as misaligned.
  function automatic size_e op_size(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = SZ_B;
      OP_LH, OP_LHU, OP_SH: op_size = SZ_H;
      OP_LW, OP_SW:         op_size = SZ_W;
      default:              op_size = SZ_BAD;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_align.sv
// Combinational byte-lane logic: big-endian lane select, store data
// replication, load lane extraction with sign/zero extension, misalign flag.
module mem_align
  import mem_ctrl_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        store_o,
  output logic        misalign_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        signed_ld;

  always_comb begin
    store_o   = (op_i == OP_SB) || (op_i == OP_SH) || (op_i == OP_SW);
    signed_ld = (op_i == OP_LB) || (op_i == OP_LH);

    case (off_i)
      2'd0:    byte_v = rdata_i[31:24];
      2'd1:    byte_v = rdata_i[23:16];
      2'd2:    byte_v = rdata_i[15:8];
      default: byte_v = rdata_i[7:0];
    endcase
    half_v = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];

    sel_o      = 4'b0000;
    wdata_o    = 32'h0;
    rdata_o    = 32'h0;
    misalign_o = 1'b0;

    case (op_size(op_i))
      SZ_B: begin
        sel_o   = 4'b1000 >> off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = signed_ld ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
      end
      SZ_H: begin
        misalign_o = off_i[0];
        sel_o      = off_i[1] ? 4'b0011 : 4'b1100;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = signed_ld ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
      end
      SZ_W: begin
        misalign_o = |off_i;
        sel_o      = 4'b1111;
        wdata_o    = wdata_i;
        rdata_o    = rdata_i;
      end
      default: misalign_o = 1'b1;
    endcase

    // Loads never drive write data; stores never return read data.
    if (store_o) rdata_o = 32'h0;
    else         wdata_o = 32'h0;
  end

endmodule

// File: rtl/mem_ctrl.sv
// MEM-stage data RAM controller: accepts one load/store, performs a single
// RAM access cycle and holds the response until the consumer takes it.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | ready for a request; request fields latched on acceptance
// ST_ACCESS | single RAM cycle; load data registered at its end
// ST_RESP   | response held on rdata_o/misalign_o until resp_ready_i
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       rdata_o,
  output logic              misalign_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [3:0]        ram_sel_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

  logic [1:0]        state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              misalign_q, misalign_d;

  logic              in_idle, in_access;
  logic [3:0]        al_op;
  logic [1:0]        al_off;
  logic [3:0]        al_sel;
  logic [31:0]       al_wdata, al_rdata;
  logic              al_store, al_misalign;

  assign in_idle   = (state_q == ST_IDLE);
  assign in_access = (state_q == ST_ACCESS);

  // In IDLE the aligner classifies the incoming request so the branch to
  // RESP or ACCESS is decided at the accepting edge; afterwards it works
  // on the latched request.
  assign al_op  = in_idle ? op_i        : op_q;
  assign al_off = in_idle ? addr_i[1:0] : addr_q[1:0];

  mem_align u_align (
    .op_i       (al_op),
    .off_i      (al_off),
    .wdata_i    (wdata_q),
    .rdata_i    (ram_rdata_i),
    .sel_o      (al_sel),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata),
    .store_o    (al_store),
    .misalign_o (al_misalign)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          op_d       = op_i;
          addr_d     = addr_i;
          wdata_d    = wdata_i;
          rdata_d    = 32'h0;
          misalign_d = al_misalign;
          state_d    = al_misalign ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        rdata_d = al_rdata;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= 4'h0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  // Reset gates ready directly so nothing is offered while rst_n is low.
  assign req_ready_o  = rst_n && in_idle;
  assign resp_valid_o = (state_q == ST_RESP);
  assign rdata_o      = rdata_q;
  assign misalign_o   = misalign_q;

  assign ram_ce_o    = in_access ? CE_ON : CE_OFF;
  assign ram_we_o    = (in_access && al_store) ? WE_WR : WE_RD;
  assign ram_sel_o   = in_access ? al_sel : 4'b0000;
  assign ram_addr_o  = in_access ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign ram_wdata_o = in_access ? al_wdata : 32'h0;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl: a driver queues expected RAM cycles and
// responses; negedge monitors compare them against the DUT and a RAM model.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, req_ready_o;
  logic [3:0]  op_i;
  logic [31:0] addr_i, wdata_i;
  logic        resp_valid_o, resp_ready_i;
  logic [31:0] rdata_o;
  logic        misalign_o;
  logic        ram_ce_o, ram_we_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_addr_o, ram_wdata_o, ram_rdata_i;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .op_i         (op_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .rdata_o      (rdata_o),
    .misalign_o   (misalign_o),
    .ram_ce_o     (ram_ce_o),
    .ram_we_o     (ram_we_o),
    .ram_sel_o    (ram_sel_o),
    .ram_addr_o   (ram_addr_o),
    .ram_wdata_o  (ram_wdata_o),
    .ram_rdata_i  (ram_rdata_i)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data RAM model, 64 words, lane bit3 = data[31:24].
  logic [31:0] mem [64];
  logic        mem_init;
  assign ram_rdata_i = mem[ram_addr_o[7:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[8]  <= 32'h80FF7F01;
      mem[12] <= 32'hDEADBEEF;
    end else if (ram_ce_o && ram_we_o) begin
      for (int l = 0; l < 4; l++)
        if (ram_sel_o[l]) mem[ram_addr_o[7:2]][l*8 +: 8] <= ram_wdata_o[l*8 +: 8];
    end
  end

  typedef struct { logic [31:0] rd; logic mis; int lat; } resp_t;
  typedef struct { logic [31:0] addr; logic [3:0] sel; logic we; logic [31:0] wd; } ram_t;
  resp_t resp_q[$];
  ram_t  ram_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: RAM port and response channel, sampled on the falling edge.
  int          acc_cyc = 0;
  logic        seen = 1'b0;
  logic [31:0] hold_rd;
  logic        hold_mis;
  resp_t       e;
  ram_t        r;

  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid_i && req_ready_o) acc_cyc = cyc + 1;

      if (ram_ce_o) begin
        if (ram_q.size() == 0) begin
          chk("ram_unexpected_ce", 32'(ram_ce_o), 32'h0);
        end else begin
          r = ram_q.pop_front();
          chk("ram_addr", ram_addr_o, r.addr);
          chk("ram_sel", 32'(ram_sel_o), 32'(r.sel));
          chk("ram_we", 32'(ram_we_o), 32'(r.we));
          if (r.we) chk("ram_wdata", ram_wdata_o, r.wd);
        end
      end else begin
        chk("ram_idle_zero",
            32'(ram_we_o | (|ram_sel_o) | (|ram_addr_o) | (|ram_wdata_o)), 32'h0);
      end

      if (resp_valid_o) begin
        chk("resp_ready_low", 32'(req_ready_o), 32'h0);
        if (resp_q.size() == 0) begin
          chk("resp_unexpected", 32'(resp_valid_o), 32'h0);
        end else begin
          if (!seen) begin
            seen     = 1'b1;
            hold_rd  = rdata_o;
            hold_mis = misalign_o;
            chk("resp_latency", 32'(cyc - acc_cyc), 32'(resp_q[0].lat));
          end else begin
            chk("resp_rdata_stable", rdata_o, hold_rd);
            chk("resp_mis_stable", 32'(misalign_o), 32'(hold_mis));
          end
          if (resp_ready_i) begin
            e    = resp_q.pop_front();
            seen = 1'b0;
            chk("resp_rdata", rdata_o, e.rd);
            chk("resp_misalign", 32'(misalign_o), 32'(e.mis));
          end
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    for (int i = 0; i < 20; i++) begin
      if (req_ready_o) break;
      @(posedge clk); #1;
    end
    chk(name, 32'(req_ready_o), 32'h1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready_o), 32'h0);
    chk({tag, "_resp_valid"}, 32'(resp_valid_o), 32'h0);
    chk({tag, "_rdata"}, rdata_o, 32'h0);
    chk({tag, "_misalign"}, 32'(misalign_o), 32'h0);
    chk({tag, "_ram_ctl"}, {26'h0, ram_ce_o, ram_we_o, ram_sel_o}, 32'h0);
    chk({tag, "_ram_addr"}, ram_addr_o, 32'h0);
    chk({tag, "_ram_wdata"}, ram_wdata_o, 32'h0);
  endtask

  // Called at posedge+1 with the DUT idle; returns with the DUT idle again.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_mis,
                       input logic [3:0] exp_sel, input logic exp_we,
                       input logic [31:0] exp_wd, input int hold);
    resp_t ex;
    ram_t  rx;
    wait_ready("ready_before_issue");
    ex.rd = exp_rd; ex.mis = exp_mis; ex.lat = exp_mis ? 0 : 1;
    resp_q.push_back(ex);
    if (!exp_mis) begin
      rx.addr = addr & 32'hFFFF_FFFC; rx.sel = exp_sel; rx.we = exp_we; rx.wd = exp_wd;
      ram_q.push_back(rx);
    end
    resp_ready_i = (hold == 0);
    op_i = op; addr_i = addr; wdata_i = wd; req_valid_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    if (hold > 0) begin
      for (int i = 0; i < 10; i++) begin
        if (resp_valid_o) break;
        @(posedge clk); #1;
      end
      chk("hold_resp_valid", 32'(resp_valid_o), 32'h1);
      repeat (hold) begin @(posedge clk); #1; end
      resp_ready_i = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_ready", 32'(req_ready_o), 32'h1);
    end else begin
      wait_ready("resp_done");
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_init = 1'b1;
    req_valid_i = 1'b0; op_i = 4'h0; addr_i = 32'h0; wdata_i = 32'h0; resp_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    mem_init = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", 32'(req_ready_o), 32'h1);
    @(posedge clk); #1;

    //     op      addr          wdata          exp_rdata      mis  sel      we    ram_wdata     hold
    issue(OP_SW,  32'h10, 32'h11223344, 32'h00000000, 1'b0, 4'b1111, 1'b1, 32'h11223344, 0);
    issue(OP_SB,  32'h13, 32'h000000AB, 32'h00000000, 1'b0, 4'b0001, 1'b1, 32'hABABABAB, 0);
    issue(OP_LW,  32'h10, 32'h0,        32'h112233AB, 1'b0, 4'b1111, 1'b0, 32'h0,        0);
    issue(OP_LB,  32'h20, 32'h0,        32'hFFFFFF80, 1'b0, 4'b1000, 1'b0, 32'h0,        0);
    issue(OP_LBU, 32'h20, 32'h0,        32'h00000080, 1'b0, 4'b1000, 1'b0, 32'h0,        0);
    issue(OP_LH,  32'h22, 32'h0,        32'h00007F01, 1'b0, 4'b0011, 1'b0, 32'h0,        0);
    issue(OP_LH,  32'h20, 32'h0,        32'hFFFF80FF, 1'b0, 4'b1100, 1'b0, 32'h0,        0);
    issue(OP_LB,  32'h21, 32'h0,        32'hFFFFFFFF, 1'b0, 4'b0100, 1'b0, 32'h0,        0);
    issue(OP_LB,  32'h22, 32'h0,        32'h0000007F, 1'b0, 4'b0010, 1'b0, 32'h0,        0);
    issue(OP_LB,  32'h23, 32'h0,        32'h00000001, 1'b0, 4'b0001, 1'b0, 32'h0,        0);
    issue(OP_LW,  32'h21, 32'h0,        32'h00000000, 1'b1, 4'b0000, 1'b0, 32'h0,        0);
    issue(OP_LH,  32'h21, 32'h0,        32'h00000000, 1'b1, 4'b0000, 1'b0, 32'h0,        0);
    issue(OP_SH,  32'h13, 32'h1234,     32'h00000000, 1'b1, 4'b0000, 1'b0, 32'h0,        0);
    issue(OP_SW,  32'h12, 32'h1234,     32'h00000000, 1'b1, 4'b0000, 1'b0, 32'h0,        0);
    issue(4'hF,   32'h10, 32'h0,        32'h00000000, 1'b1, 4'b0000, 1'b0, 32'h0,        0);
    issue(OP_SH,  32'h12, 32'h0000BEEF, 32'h00000000, 1'b0, 4'b0011, 1'b1, 32'hBEEFBEEF, 0);
    issue(OP_LHU, 32'h12, 32'h0,        32'h0000BEEF, 1'b0, 4'b0011, 1'b0, 32'h0,        0);
    issue(OP_LBU, 32'h11, 32'h0,        32'h00000022, 1'b0, 4'b0100, 1'b0, 32'h0,        0);
    issue(OP_LW,  32'h20, 32'h0,        32'h80FF7F01, 1'b0, 4'b1111, 1'b0, 32'h0,        5);

    // Store aborted by reset while its RAM cycle is on the bus.
    wait_ready("ready_before_abort");
    op_i = OP_SW; addr_i = 32'h30; wdata_i = 32'h12345678; req_valid_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    chk("abort_in_access", 32'(ram_ce_o), 32'h1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    repeat (2) begin @(posedge clk); #1; end
    chk("abort_mem_unchanged", mem[12], 32'hDEADBEEF);
    rst_n = 1'b1;
    #1;
    chk("ready_after_abort", 32'(req_ready_o), 32'h1);
    @(posedge clk); #1;
    issue(OP_LW,  32'h30, 32'h0,        32'hDEADBEEF, 1'b0, 4'b1111, 1'b0, 32'h0,        0);

    repeat (3) @(posedge clk);
    #1;
    chk("resp_queue_empty", 32'(resp_q.size()), 32'h0);
    chk("ram_queue_empty", 32'(ram_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk, rst_n.
REQ-002 Parameter ADDR_W SHALL be provided: default 32; width of request and RAM byte addresses.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_valid_i  in  1  MEM-stage access request present.
REQ-006 req_ready_o  out  1  block can accept a request.
REQ-007 op_i  in  4  access type; one of LB, LBU, LH, LHU, LW, SB, SH, SW.
REQ-008 addr_i  in  ADDR_W  byte address.
REQ-009 wdata_i  in  32  store data, right-justified.
REQ-010 resp_valid_o  out  1  response present.
REQ-011 resp_ready_i  in  1  consumer accepts the response.
REQ-012 rdata_o  out  32  load result, extended to 32 bits; zero for stores.
REQ-013 misalign_o  out  1  request was misaligned; no RAM access was made.
REQ-014 ram_ce_o, ram_we_o  out  1 each  data RAM chip enable and write enable.
REQ-015 ram_sel_o  out  4  RAM byte-lane select; bit3 = data[31:24].
REQ-016 ram_addr_o  out  ADDR_W  RAM address; ram_wdata_o out 32; ram_rdata_i in 32 (combinational read data).

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-018 In IDLE, req_ready_o SHALL be 1; in every other state it SHALL be 0.
REQ-019 In IDLE with req_valid_i=1, the block SHALL latch op_i, addr_i and wdata_i at the clock edge.
REQ-020 After that latch, the FSM SHALL go to RESP with misalign_o=1 if the request is misaligned, otherwise to ACCESS.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-021 In ACCESS, exactly for one cycle, the block SHALL drive:
- ram_ce_o=1
- ram_we_o=1 for stores, 0 for loads
- ram_addr_o = latched address with bits [1:0] forced to 0
REQ-022 ram_sel_o SHALL use big-endian lane mapping:
- byte offsets 0/1/2/3 -> 1000/0100/0010/0001
- halfword offsets 0/2 -> 1100/0011
- word -> 1111
REQ-023 ram_wdata_o SHALL replicate the store data: SB -> {4{wdata[7:0]}}, SH -> {2{wdata[15:0]}}, SW -> wdata.
REQ-024 For loads, at the end of ACCESS the block SHALL register the selected lane(s) of ram_rdata_i into rdata_o.
- LB/LH: sign-extended.
- LBU/LHU: zero-extended.
REQ-025 Outside ACCESS, all ram_* outputs SHALL be 0 (chip disabled, no write).
REQ-026 In RESP, resp_valid_o SHALL be 1, with rdata_o and misalign_o held stable until resp_ready_i=1; the FSM then returns to IDLE.
REQ-027 Latency SHALL be: request accepted at edge N, RAM access in cycle N+1, resp_valid_o high from cycle N+2; a misaligned request raises resp_valid_o from cycle N+1.
REQ-028 A new request SHALL NOT be accepted in the same cycle a response completes; the minimum issue interval is 3 cycles.
REQ-029 An op_i value outside the eight defined codes SHALL be treated as misaligned (misalign_o=1, no RAM access).

Reset
REQ-030 While rst_n=0, the block SHALL force: state=IDLE, req_ready_o=0, resp_valid_o=0, rdata_o=0, misalign_o=0, all ram_* outputs=0, latched request=0.
REQ-031 When reset is asserted mid-ACCESS or mid-RESP, the block SHALL abort immediately with no RAM write completing after reset assertion, and no response SHALL be delivered for the aborted request.
REQ-032 After reset deassertion, req_ready_o SHALL be 1 from the first cycle.

Structure
REQ-033 The shared constants header const.v SHALL hold the op_i codes, the state encodings and the chip/write enable levels.
REQ-034 A combinational sub-module mem_align SHALL hold the lane logic: op + offset -> sel, wdata replication, rdata extraction/extension and the misalign flag.
REQ-035 The target size SHALL be 120-400 lines of RTL in total.

Verification
REQ-036 SW addr=0x10 wdata=0x11223344 -> one ACCESS cycle, ce=1 we=1 sel=1111 ram_addr=0x10; resp at N+2, rdata=0.
REQ-037 SB addr=0x13 wdata=0x000000AB -> sel=0001, ram_wdata=0xABABABAB; then LW 0x10 -> rdata=0x112233AB.
REQ-038 RAM word at 0x20 = 0x80FF7F01: LB 0x20 -> 0xFFFFFF80; LBU 0x20 -> 0x00000080; LH 0x22 -> 0x00007F01; LH 0x20 -> 0xFFFF80FF.
REQ-039 LW 0x21 -> no ram_ce pulse; resp_valid at N+1 with misalign_o=1, rdata=0.
REQ-040 LW with resp_ready_i=0 for 5 cycles -> resp_valid_o and rdata_o stable for those cycles, req_ready_o=0 throughout; IDLE one cycle after resp_ready_i=1.
REQ-041 SW with rst_n asserted during ACCESS -> RAM contents unchanged if reset precedes the edge, no response, all outputs 0; the next request then completes normally.
